program_loader: RTL and testbench

Boot-time writer for the instruction memory: accepts a byte stream (count header followed by big-endian instruction words), assembles 32-bit instructions and issues single-cycle write strobes into a writable program memory at byte addresses starting from the text-segment base 0x00400000. It sits between a byte source (UART receiver or testbench) and the program-memory write port. It holds the core in stall via `Busy` until the image is fully written.

---
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time instruction loader: count header + big-endian words -> program memory writes.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int                    MEMORY_DEPTH = 1024,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t      state, next;
    logic [7:0]  count_hi;
    logic [15:0] count, index;
    logic [1:0]  bcnt;
    logic [31:0] asm_q;
    logic [15:0] n_rx;
    logic        bad_count, last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign n_rx      = {count_hi, byte_data};
    assign bad_count = (n_rx == 16'd0) || ({1'b0, n_rx} > 17'(MEMORY_DEPTH));
    assign last_word = (index == count - 16'd1);

    // byte_ready never depends on byte_valid, so byte_valid alone marks a transfer
    always_comb begin
        next       = state;
        byte_ready = 1'b0;
        MemWrite   = 1'b0;
        Busy       = 1'b1;
        Done       = (state == DONE);
        Error      = (state == ERROR);
        case (state)
            IDLE, DONE, ERROR: begin
                Busy = 1'b0;
                if (start) next = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) next = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) next = bad_count ? ERROR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && bcnt == 2'd3) next = WRITE;
            end
            WRITE: begin
                MemWrite = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                next = last_word ? CHECK : DATA;
`else
                next = last_word ? DONE : DATA;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) next = (byte_data == csum) ? DONE : ERROR;
            end
`endif
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count_hi     <= '0;
            count        <= '0;
            index        <= '0;
            bcnt         <= '0;
            asm_q        <= '0;
            WriteAddress <= BASE_ADDRESS;
            WriteData    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state <= next;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        index <= '0;
                        bcnt  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                LEN_HI: if (byte_valid) count_hi <= byte_data;
                LEN_LO: if (byte_valid) count <= n_rx;
                DATA: begin
                    if (byte_valid) begin
                        asm_q <= {asm_q[23:0], byte_data};
                        bcnt  <= bcnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum  <= csum ^ byte_data;
`endif
                        // address/data latched here so they are stable for the whole WRITE cycle and after
                        if (bcnt == 2'd3) begin
                            WriteAddress <= BASE_ADDRESS + DATA_WIDTH'({index, 2'b00});
                            WriteData    <= DATA_WIDTH'({asm_q[23:0], byte_data});
                        end
                    end
                end
                WRITE: index <= index + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random word images vs. a queue-based write model.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h00400000;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, MemWrite, Busy, Done, Error;
    logic [31:0] WriteAddress, WriteData;

    int checks = 0;
    int errors = 0;

    logic [31:0] words[$];
    logic [7:0]  stream[$];
    logic [63:0] expw[$];
    logic [63:0] got[$];
    int          rdy_viol = 0;

    program_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .MemWrite(MemWrite), .WriteAddress(WriteAddress), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (MemWrite === 1'b1) begin
            got.push_back({WriteAddress, WriteData});
            if (byte_ready !== 1'b0) rdy_viol++;
        end
    end

    // Image model: header, MSB-first words, optional XOR byte; expected writes at BASE + 4*i.
    task automatic build(input logic [15:0] n_hdr);
        logic [7:0] x, by;
        x = 8'h00;
        stream.delete();
        expw.delete();
        stream.push_back(n_hdr[15:8]);
        stream.push_back(n_hdr[7:0]);
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                by = words[i][8*b +: 8];
                stream.push_back(by);
                x ^= by;
            end
            expw.push_back({BASE + 32'(i) * 32'd4, words[i]});
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Returns at the negedge following the posedge that took the last byte.
    task automatic send(input int gap);
        int i = 0;
        int guard = 0;
        while (i < stream.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (gap > 0 && $urandom_range(0, 99) < gap) byte_valid = 1'b0;
            else begin
                byte_valid = 1'b1;
                byte_data  = stream[i];
            end
            if (byte_valid && byte_ready) i++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (guard >= 4000) begin
            errors++;
            $display("FAIL send_timeout sent %0d of %0d bytes", i, stream.size());
        end
    endtask

    task automatic wait_end();
        int k = 0;
        while (Done !== 1'b1 && Error !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL end_timeout Done=%b Error=%b", Done, Error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks += 7;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", byte_ready); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite got %b exp 0", MemWrite); end
        if (WriteAddress !== BASE) begin errors++; $display("FAIL rst_addr got %h exp %h", WriteAddress, BASE); end
        if (WriteData !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", WriteData); end
        if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", Busy); end
        if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", Done); end
        if (Error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", Error); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        words = '{32'h20080005, 32'h01095020};
        build(16'd2);
        got.delete();
        rdy_viol = 0;
        pulse_start();
        checks++;
        if (Busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++; $display("FAIL start_busy got busy=%b ready=%b exp 1/1", Busy, byte_ready);
        end
        send(0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        checks++;
        if (MemWrite !== 1'b1) begin errors++; $display("FAIL last_strobe got %b exp 1", MemWrite); end
        @(negedge clk);
`endif
        checks += 3;
        if (Done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", Done); end
        if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", Busy); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL basic_strobe_len got %b exp 0", MemWrite); end
        repeat (2) @(negedge clk);
        checks += 4;
        if (got.size() != 2) begin errors++; $display("FAIL basic_nwrites got %0d exp 2", got.size()); end
        foreach (expw[i]) if (i < got.size() && got[i] !== expw[i]) begin
            errors++; $display("FAIL basic_write%0d got %h exp %h", i, got[i], expw[i]);
        end
        if (WriteAddress !== 32'h00400004 || WriteData !== 32'h01095020) begin
            errors++; $display("FAIL basic_hold got %h/%h exp 00400004/01095020", WriteAddress, WriteData);
        end
        checks++;
        if (rdy_viol != 0) begin errors++; $display("FAIL basic_ready_in_write got %0d exp 0", rdy_viol); end
    endtask

    task automatic test_bad_count();
        logic [15:0] cnts[2];
        cnts[0] = 16'h0000;
        cnts[1] = 16'h0401;
        foreach (cnts[c]) begin
            words.delete();
            build(cnts[c]);
            while (stream.size() > 2) void'(stream.pop_back());
            got.delete();
            pulse_start();
            send(0);
            checks += 3;
            if (Error !== 1'b1) begin errors++; $display("FAIL bad%0d_error got %b exp 1", c, Error); end
            if (Busy !== 1'b0) begin errors++; $display("FAIL bad%0d_busy got %b exp 0", c, Busy); end
            if (byte_ready !== 1'b0) begin errors++; $display("FAIL bad%0d_ready got %b exp 0", c, byte_ready); end
            repeat (3) @(negedge clk);
            checks++;
            if (got.size() != 0) begin errors++; $display("FAIL bad%0d_writes got %0d exp 0", c, got.size()); end
        end
    endtask

    task automatic test_gaps();
        for (int it = 0; it < 5; it++) begin
            if (it > 1) rand_words($urandom_range(1, 6));
            else if (it == 0) rand_words(3);
            build(16'(words.size()));
            got.delete();
            rdy_viol = 0;
            pulse_start();
            send(it == 0 ? 0 : 40);
            wait_end();
            repeat (2) @(negedge clk);
            checks += 3;
            if (Done !== 1'b1) begin errors++; $display("FAIL gaps%0d_done got %b exp 1", it, Done); end
            if (got.size() != expw.size()) begin
                errors++; $display("FAIL gaps%0d_nwrites got %0d exp %0d", it, got.size(), expw.size());
            end
            if (rdy_viol != 0) begin errors++; $display("FAIL gaps%0d_ready_in_write got %0d exp 0", it, rdy_viol); end
            foreach (expw[i]) begin
                checks++;
                if (i >= got.size() || got[i] !== expw[i]) begin
                    errors++; $display("FAIL gaps%0d_write%0d exp %h", it, i, expw[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] full[$];
        rand_words(4);
        build(16'd4);
        full = stream;
        while (stream.size() > 12) void'(stream.pop_back());
        got.delete();
        pulse_start();
        send(0);
        repeat (2) @(negedge clk);
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL mid_prewrites got %0d exp 2", got.size()); end
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (Busy !== 1'b0 || byte_ready !== 1'b0 || MemWrite !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl got busy=%b ready=%b mw=%b exp 0", Busy, byte_ready, MemWrite);
        end
        if (WriteAddress !== BASE) begin errors++; $display("FAIL mid_addr got %h exp %h", WriteAddress, BASE); end
        if (WriteData !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", WriteData); end
        if (Done !== 1'b0 || Error !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b exp 00", Done, Error); end
        reset = 1'b0;
        stream = full;
        got.delete();
        pulse_start();
        send(0);
        wait_end();
        repeat (2) @(negedge clk);
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL mid_nwrites got %0d exp 4", got.size()); end
        foreach (expw[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== expw[i]) begin
                errors++; $display("FAIL mid_write%0d exp %h", i, expw[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        rand_words(3);
        build(16'd3);
        got.delete();
        pulse_start();
        fork
            send(20);
            begin
                repeat (8) @(negedge clk);
                start = 1'b1;
                checks++;
                if (Busy !== 1'b1) begin errors++; $display("FAIL sb_busy got %b exp 1", Busy); end
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_end();
        repeat (2) @(negedge clk);
        checks += 2;
        if (Done !== 1'b1) begin errors++; $display("FAIL sb_done got %b exp 1", Done); end
        if (got.size() != 3) begin errors++; $display("FAIL sb_nwrites got %0d exp 3", got.size()); end
        foreach (expw[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== expw[i]) begin
                errors++; $display("FAIL sb_write%0d exp %h", i, expw[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        rand_words(2);
        build(16'd2);
        got.delete();
        pulse_start();
        send(0);
        wait_end();
        rand_words(2);
        build(16'd2);
        got.delete();
        pulse_start();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart got done=%b busy=%b exp 0/1", Done, Busy);
        end
        send(0);
        wait_end();
        repeat (2) @(negedge clk);
        foreach (expw[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== expw[i]) begin
                errors++; $display("FAIL b2b_write%0d exp %h", i, expw[i]);
            end
        end
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        words = '{32'h12345678};
        for (int k = 0; k < 2; k++) begin
            build(16'd1);
            if (k == 1) stream[stream.size() - 1] = 8'h09;
            got.delete();
            pulse_start();
            send(0);
            checks += 3;
            if (Done !== (k == 0)) begin errors++; $display("FAIL cs%0d_done got %b exp %b", k, Done, k == 0); end
            if (Error !== (k == 1)) begin errors++; $display("FAIL cs%0d_error got %b exp %b", k, Error, k == 1); end
            if (got.size() != 1 || got[0] !== {BASE, 32'h12345678}) begin
                errors++; $display("FAIL cs%0d_write got n=%0d exp 1 write of 12345678", k, got.size());
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        test_reset();
        test_basic();
        test_bad_count();
        test_gaps();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
